// File: rtl/ans_table_arbiter.sv
// ans_table_arbiter: round-robin share of one frequency-table read port between
//   r0 (ans_encoder) and r1 (ans_decoder), one lookup in flight at a time.
// Latency: request -> t_type/t_query 1 cycle; t_rdy -> rN_rdy/rN_result 1 cycle.
// Backpressure: losing requester holds its request until the owner releases;
//   table stall beyond TIMEOUT enabled cycles aborts with result 0 and sticky err.
//
// Ports:
//   clk, rst_n (async active-low), ena (clock enable, 0 freezes all state)
//   r0_type/r0_query -> r0_result/r0_rdy   requester 0 (level-held protocol)
//   r1_type/r1_query -> r1_result/r1_rdy   requester 1 (level-held protocol)
//   t_type/t_query -> t_result/t_rdy       shared table read port
//   err                                    sticky table-timeout flag
module ans_table_arbiter #(
    parameter int CNT_WIDTH = 16,
    parameter int SYM_WIDTH = 8,
    parameter int QW        = CNT_WIDTH + SYM_WIDTH,
    parameter int TIMEOUT   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [1:0]    r0_type,
    input  logic [QW-1:0] r0_query,
    output logic [QW-1:0] r0_result,
    output logic          r0_rdy,
    input  logic [1:0]    r1_type,
    input  logic [QW-1:0] r1_query,
    output logic [QW-1:0] r1_result,
    output logic          r1_rdy,
    output logic [1:0]    t_type,
    output logic [QW-1:0] t_query,
    input  logic [QW-1:0] t_result,
    input  logic          t_rdy,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] TYPE_NONE = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_owner;
    logic           r_last_grant;
    logic [CW-1:0]  r_count;
    logic [1:0]     r_t_type;
    logic [QW-1:0]  r_t_query;
    logic [QW-1:0]  r_r0_result;
    logic [QW-1:0]  r_r1_result;
    logic           r_r0_rdy;
    logic           r_r1_rdy;
    logic           r_err;

    logic           w_req0;
    logic           w_req1;
    logic           w_pick;
    logic [1:0]     w_owner_type;
    logic           w_timeout;
    logic [QW-1:0]  w_post_val;

    assign w_req0 = (r0_type != TYPE_NONE);
    assign w_req1 = (r1_type != TYPE_NONE);
    // On a tie the requester that did not win last time gets the port.
    assign w_pick = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
    assign w_owner_type = r_owner ? r1_type : r0_type;
    // The count value seen on the TIMEOUT-th enabled BUSY cycle is TIMEOUT-1.
    assign w_timeout  = (r_count == CW'(TIMEOUT - 1));
    // An aborted lookup releases the owner with a zero result.
    assign w_post_val = t_rdy ? t_result : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_count      <= '0;
            r_t_type     <= TYPE_NONE;
            r_t_query    <= '0;
            r_r0_result  <= '0;
            r_r1_result  <= '0;
            r_r0_rdy     <= 1'b0;
            r_r1_rdy     <= 1'b0;
            r_err        <= 1'b0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    // A still-high t_rdy belongs to the previous lookup; wait it out.
                    if ((w_req0 || w_req1) && !t_rdy) begin
                        r_owner      <= w_pick;
                        r_last_grant <= w_pick;
                        r_t_type     <= w_pick ? r1_type  : r0_type;
                        r_t_query    <= w_pick ? r1_query : r0_query;
                        r_count      <= '0;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (t_rdy || w_timeout) begin
                        if (r_owner) begin
                            r_r1_result <= w_post_val;
                            r_r1_rdy    <= 1'b1;
                        end else begin
                            r_r0_result <= w_post_val;
                            r_r0_rdy    <= 1'b1;
                        end
                        r_t_type <= TYPE_NONE;
                        if (!t_rdy) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_HOLD;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (w_owner_type == TYPE_NONE) begin
                        r_r0_rdy <= 1'b0;
                        r_r1_rdy <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign t_type    = r_t_type;
    assign t_query   = r_t_query;
    assign r0_result = r_r0_result;
    assign r1_result = r_r1_result;
    assign r0_rdy    = r_r0_rdy;
    assign r1_rdy    = r_r1_rdy;
    assign err       = r_err;

endmodule
